// File: rtl/branch_cond_unit.sv
// ---------------------------------------------------------------------------
// branch_cond_unit
//
// Resolves SPARC Bicc branches. Holds the architectural icc register,
// evaluates the 4-bit condition field against it, issues a one-cycle fetch
// redirect with the computed target, and tracks the delay slot that follows
// every Bicc, including annulment.
//
// Handshake: the stage presents one instruction at a time. It is consumed on
// a rising edge where advance=1. While advance=0, the stage is stalled: the
// same instruction stays presented, and nothing inside this unit changes
// except that redirect and dcti_err return to 0.
//
// Parameters
//   BYPASS      1: a branch accepted together with an icc write evaluates on
//                  the incoming flags. 0: it evaluates on the stored icc only.
//
// Ports
//   clk, rst_n              clock; synchronous active-low reset
//   advance                 stage consumes its instruction this cycle
//   icc_we                  instruction is a cc-modifying ALU op
//   n_in, z_in, v_in, c_in  ALU flag outputs
//   br_valid                instruction is a Bicc
//   cond, a_bit, disp22     Bicc fields instr[28:25], instr[29], instr[21:0]
//   pc_in                   address of the instruction in the stage
//   n, z, v, c              stored icc; c feeds the ALU carry-in
//   redirect, target        one-cycle fetch redirect and its target address
//   annul_slot              instruction in the stage is an annulled delay slot
//   dcti_err                one-cycle pulse: Bicc found in an executed slot
//   state                   FSM state for observation (0 IDLE, 1 SLOT_EXEC,
//                           2 SLOT_ANNUL)
// ---------------------------------------------------------------------------
module branch_cond_unit #(
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    input  logic        icc_we,
    input  logic        n_in,
    input  logic        z_in,
    input  logic        v_in,
    input  logic        c_in,
    input  logic        br_valid,
    input  logic [3:0]  cond,
    input  logic        a_bit,
    input  logic [21:0] disp22,
    input  logic [31:0] pc_in,
    output logic        n,
    output logic        z,
    output logic        v,
    output logic        c,
    output logic        redirect,
    output logic [31:0] target,
    output logic        annul_slot,
    output logic        dcti_err,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SLOT_EXEC  = 2'd1,
        SLOT_ANNUL = 2'd2
    } state_t;

    state_t cur_state;

    // Lower three cond bits select a base test; cond[3] inverts it.
    function automatic logic cond_true(input logic [3:0] cc,
                                       input logic fn, input logic fz,
                                       input logic fv, input logic fc);
        logic r;
        case (cc[2:0])
            3'd0:    r = 1'b0;
            3'd1:    r = fz;
            3'd2:    r = fz | (fn ^ fv);
            3'd3:    r = fn ^ fv;
            3'd4:    r = fc | fz;
            3'd5:    r = fc;
            3'd6:    r = fn;
            default: r = fv;
        endcase
        return cc[3] ? ~r : r;
    endfunction

    logic [3:0]  eval_flags;
    logic        taken;
    logic        annul;
    logic [31:0] branch_target;

    always_comb begin
        // The incoming flags only matter when an icc write lands in the same
        // cycle; otherwise the branch sees what is stored.
        if ((BYPASS != 0) && icc_we)
            eval_flags = {n_in, z_in, v_in, c_in};
        else
            eval_flags = {n, z, v, c};
        taken = cond_true(cond, eval_flags[3], eval_flags[2],
                          eval_flags[1], eval_flags[0]);
        // BA,a annuls its slot even though it is taken.
        annul = a_bit & (~taken | (cond == 4'b1000));
        // Word displacement, sign-extended and scaled to bytes; wraps mod 2^32.
        branch_target = pc_in + {{8{disp22[21]}}, disp22, 2'b00};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state  <= IDLE;
            n          <= 1'b0;
            z          <= 1'b0;
            v          <= 1'b0;
            c          <= 1'b0;
            redirect   <= 1'b0;
            target     <= 32'd0;
            annul_slot <= 1'b0;
            dcti_err   <= 1'b0;
        end else begin
            // Pulses last exactly one cycle regardless of stalls.
            redirect <= 1'b0;
            dcti_err <= 1'b0;
            if (advance) begin
                case (cur_state)
                    IDLE: begin
                        if (icc_we) begin
                            {n, z, v, c} <= {n_in, z_in, v_in, c_in};
                        end
                        if (br_valid) begin
                            if (taken) begin
                                redirect <= 1'b1;
                                target   <= branch_target;
                            end
                            cur_state  <= annul ? SLOT_ANNUL : SLOT_EXEC;
                            annul_slot <= annul;
                        end
                    end
                    SLOT_EXEC: begin
                        if (icc_we) begin
                            {n, z, v, c} <= {n_in, z_in, v_in, c_in};
                        end
                        // A branch in an executed slot is not evaluated.
                        dcti_err   <= br_valid;
                        cur_state  <= IDLE;
                        annul_slot <= 1'b0;
                    end
                    SLOT_ANNUL: begin
                        // Annulled instruction: no icc write, no branch.
                        cur_state  <= IDLE;
                        annul_slot <= 1'b0;
                    end
                    default: begin
                        cur_state  <= IDLE;
                        annul_slot <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state = cur_state;

endmodule

// File: doc/branch_cond_unit.md
# branch_cond_unit

Consumes the N/Z/V/C integer condition codes produced by the ALU's cc-modifying operations and resolves SPARC Bicc branches. It holds the architectural icc register and evaluates the 4-bit condition field. It issues a one-cycle PC redirect with the computed target and tracks the delayed-branch slot, including annulment. It sits between the ALU flag outputs and the PC/fetch logic. Its registered C also feeds the ALU `Cin` for ADDX/SUBX.

## Interface
Parameters:
- BYPASS, 1, 1 = a branch accepted in the same cycle as an icc write evaluates on the incoming flags; 0 = evaluates on the stored icc only.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, synchronous, active-low; one clock, sampled on rising edge
- advance  in  1  pipeline stage accepts its instruction this cycle; stall when 0
- icc_we  in  1  instruction in stage is a cc-modifying ALU op (ADDcc, SUBcc, ANDcc, etc.)
- n_in, z_in, v_in, c_in  in  1 each  ALU flag outputs
- br_valid  in  1  instruction in stage is Bicc
- cond  in  4  Bicc cond field, instr[28:25]
- a_bit  in  1  annul bit, instr[29]
- disp22  in  22  word displacement, instr[21:0]
- pc_in  in  32  address of the instruction in stage
- n, z, v, c  out  1 each  stored icc; c drives ALU Cin
- redirect  out  1  one-cycle pulse: fetch must load target
- target  out  32  branch target, valid while redirect=1
- annul_slot  out  1  current instruction in stage is an annulled delay slot
- dcti_err  out  1  one-cycle pulse: branch found in an executed delay slot

## Operation
- Accepted branch: br_valid & advance in state IDLE.
- Accepted icc write: icc_we & advance, and state is not SLOT_ANNUL. On an accepted write, {n,z,v,c} <= {n_in,z_in,v_in,c_in}. An annulled instruction never writes icc.
- Evaluation flags:
  - When BYPASS=1 and an icc write is accepted in the same cycle as the branch, the incoming flags are used.
  - Otherwise the stored icc is used.
- Conditions (cond: taken when):
  - 1000 always; 0000 never
  - 1001 ~Z; 0001 Z
  - 1010 ~(Z|(N^V)); 0010 Z|(N^V)
  - 1011 ~(N^V); 0011 N^V
  - 1100 ~(C|Z); 0100 C|Z
  - 1101 ~C; 0101 C
  - 1110 ~N; 0110 N
  - 1111 ~V; 0111 V
- Target: target = pc_in + (sign_extend(disp22) << 2), computed mod 2^32 (wrap, no error).
- Annul decision:
  - a_bit=1 and not taken: annul.
  - a_bit=1 and cond=1000 (BA): annul even though taken.
  - Otherwise the slot executes.
- FSM:
  - IDLE:
    - Accepted branch, annul: go to SLOT_ANNUL.
    - Accepted branch, no annul: go to SLOT_EXEC.
    - Taken branches also load target and pulse redirect. BN with a_bit=0 still goes to SLOT_EXEC.
  - SLOT_EXEC:
    - Waits for the delay-slot instruction. advance=1 returns to IDLE.
    - br_valid & advance here: the branch is not evaluated, dcti_err pulses, state returns to IDLE.
  - SLOT_ANNUL:
    - annul_slot=1. advance=1 returns to IDLE.
    - br_valid and icc_we in this state are ignored silently.
- With advance=0 nothing changes: no state move, no icc write, no branch acceptance.

## Timing
- Reset values: n=z=v=c=0, redirect=0, target=0, annul_slot=0, dcti_err=0, state IDLE.
- Reset mid-slot returns to IDLE with all outputs at reset values the following cycle. A pending redirect is dropped.
- Latency:
  - Branch accepted at edge k: redirect, target and annul_slot are valid from k+1.
  - redirect is exactly one cycle wide, even if advance=0 at k+1.
- annul_slot is a registered state decode. It stays high across stalls until the advancing edge, and falls the cycle after.
- icc written at edge k is visible on n/z/v/c from k+1. A branch accepted at k+1 sees the value without bypass.
- Simultaneous icc_we and branch acceptance in IDLE: the icc update happens, and the evaluation uses the flags selected by BYPASS.
- target holds its last value when redirect=0.

## Test plan
- BE taken: stored Z=1, pc_in=0x00000100, disp22=0x000004, cond=0001, a=0. Required: redirect pulses one cycle, target=0x00000110, annul_slot=0, state SLOT_EXEC until the next advance.
- BNE,a untaken: Z=1, cond=1001, a=1. Required: no redirect, annul_slot=1 held through 3 stall cycles. icc_we with z_in=0 during the slot leaves Z=1.
- BA,a wrap: pc_in=0x00000000, disp22=0x3FFFFF, cond=1000, a=1. Required: redirect, target=0xFFFFFFFC, annul_slot=1.
- Bypass: stored Z=0, icc_we=1 with z_in=1 in the same cycle as BE. Required: taken with BYPASS=1, not taken with BYPASS=0. In both cases z=1 afterwards.
- Signed/unsigned conditions:
  - N=1, V=0, BL (0011): taken.
  - BGE (1011): not taken.
  - C=0, Z=0, BGU (1100): taken.
  - C=1, BLEU (0100): taken.
- Exceptions:
  - Branch in an executed slot: dcti_err pulses for one cycle, no redirect.
  - rst_n=0 in SLOT_ANNUL: all outputs are 0 and the state is IDLE on the next cycle.
